// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control unit for the 16-bit datapath: fetch, decode and sequencing of
// R-type, LOAD, STORE and Jcond instructions over a ready/request memory port.
//
// state  | meaning
// RESET  | all strobes low, ir cleared; leaves to FETCH once reset is low
// FETCH  | PC addresses memory; ir captures instr on mem_ready
// DECODE | no strobes; picks EXEC / LOAD / STORE / JUMP or flags an illegal ext
// EXEC   | ALU result and flags written, PC advances
// LOAD   | Rsrc addresses memory; memory data written to Rdest on mem_ready
// STORE  | Rsrc addresses memory, Rdest supplies data; completes on mem_ready
// JUMP   | PC advances or loads the Rsrc target depending on the condition
module cpu_ctrl_fsm #(
    parameter int REG_N       = 16,
    parameter int SEL_W       = $clog2(REG_N),
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       instr,
    input  logic              mem_ready,
    input  logic [4:0]        flags,
    output logic [15:0]       ir,
    output logic [7:0]        alu_op,
    output logic [SEL_W-1:0]  ra_sel,
    output logic [SEL_W-1:0]  rb_sel,
    output logic [REG_N-1:0]  reg_en,
    output logic              flag_en,
    output logic              alu_sel,
    output logic              addr_sel,
    output logic              mem_req,
    output logic              mem_we,
    output logic              pc_en,
    output logic              pc_sel,
    output logic              illegal,
    output logic              bus_err
);

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_LOAD   = 3'd4;
    localparam logic [2:0] S_STORE  = 3'd5;
    localparam logic [2:0] S_JUMP   = 3'd6;

    localparam int               CNT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LOAD = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;
    localparam bit               TO_EN    = (MEM_TIMEOUT != 0);
    localparam logic [4:0]       REG_LIM  = 5'(REG_N);
    localparam logic [REG_N-1:0] REG_ONE  = REG_N'(1);

    logic [2:0]       state;
    logic [2:0]       next_state;
    logic             from_decode;
    logic [CNT_W-1:0] wait_cnt;

    logic [3:0]       cls;
    logic [3:0]       rdest;
    logic [3:0]       ext;
    logic [3:0]       rsrc;
    logic             rdest_bad;
    logic             rsrc_bad;
    logic             mem_bad;
    logic             is_cmp;
    logic [REG_N-1:0] rdest_hot;
    logic             waiting;
    logic             accept;
    logic             timeout;
    logic             taken;
    logic             f_n, f_z, f_f, f_l, f_c;

    assign cls   = ir[15:12];
    assign rdest = ir[11:8];
    assign ext   = ir[7:4];
    assign rsrc  = ir[3:0];

    assign alu_op = {ir[15:12], ir[7:4]};
    assign ra_sel = ir[8 +: SEL_W];
    assign rb_sel = ir[0 +: SEL_W];

    assign rdest_bad = ({1'b0, rdest} >= REG_LIM);
    assign rsrc_bad  = ({1'b0, rsrc} >= REG_LIM);
    assign mem_bad   = rdest_bad | rsrc_bad;
    assign is_cmp    = (cls == 4'b0000) && (ext == 4'b1011);
    assign rdest_hot = REG_ONE << rdest;

    // The first LOAD/STORE cycle only presents the address; mem_ready is accepted
    // from the second cycle on, which gives the four-cycle zero-wait memory ops.
    assign waiting = (state == S_FETCH) ||
                     (((state == S_LOAD) || (state == S_STORE)) && !from_decode);
    assign accept  = waiting && mem_ready;
    assign timeout = TO_EN && waiting && !mem_ready && (wait_cnt == '0);

    assign {f_n, f_z, f_f, f_l, f_c} = flags;

    always_comb begin
        case (rdest)
            4'h0:    taken = f_z;
            4'h1:    taken = !f_z;
            4'h2:    taken = f_c;
            4'h3:    taken = !f_c;
            4'h4:    taken = f_l;
            4'h5:    taken = !f_l;
            4'h6:    taken = f_n;
            4'h7:    taken = !f_n;
            4'h8:    taken = f_f;
            4'h9:    taken = !f_f;
            4'hA:    taken = !f_l && !f_z;
            4'hB:    taken = f_l || f_z;
            4'hC:    taken = !f_n && !f_z;
            4'hD:    taken = f_n || f_z;
            4'hE:    taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        next_state = state;
        reg_en     = '0;
        flag_en    = 1'b0;
        alu_sel    = 1'b0;
        addr_sel   = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        pc_en      = 1'b0;
        pc_sel     = 1'b0;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        if (reset) begin
            next_state = S_RESET;
        end else begin
            case (state)
                S_RESET: next_state = S_FETCH;
                S_FETCH: begin
                    mem_req = !timeout;
                    bus_err = timeout;
                    if (accept) next_state = S_DECODE;
                end
                S_DECODE: begin
                    if (cls != 4'b0100) begin
                        next_state = S_EXEC;
                    end else begin
                        case (ext)
                            4'b0000: next_state = S_LOAD;
                            4'b0100: next_state = S_STORE;
                            4'b1100: next_state = S_JUMP;
                            default: begin
                                illegal    = 1'b1;
                                pc_en      = 1'b1;
                                next_state = S_FETCH;
                            end
                        endcase
                    end
                end
                S_EXEC: begin
                    alu_sel    = 1'b1;
                    flag_en    = 1'b1;
                    pc_en      = 1'b1;
                    if (!is_cmp) begin
                        if (rdest_bad) illegal = 1'b1;
                        else           reg_en  = rdest_hot;
                    end
                    next_state = S_FETCH;
                end
                S_LOAD: begin
                    mem_req  = !timeout;
                    addr_sel = 1'b1;
                    bus_err  = timeout;
                    if (accept) begin
                        pc_en      = 1'b1;
                        illegal    = mem_bad;
                        reg_en     = mem_bad ? '0 : rdest_hot;
                        next_state = S_FETCH;
                    end else if (timeout) begin
                        pc_en      = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_STORE: begin
                    // An out-of-range register turns the store into a harmless no-write access.
                    mem_req  = !timeout;
                    mem_we   = !timeout && !mem_bad;
                    addr_sel = 1'b1;
                    bus_err  = timeout;
                    if (accept) begin
                        pc_en      = 1'b1;
                        illegal    = mem_bad;
                        next_state = S_FETCH;
                    end else if (timeout) begin
                        pc_en      = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_JUMP: begin
                    pc_en      = 1'b1;
                    illegal    = rsrc_bad;
                    pc_sel     = taken && !rsrc_bad;
                    next_state = S_FETCH;
                end
                default: next_state = S_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RESET;
            ir          <= '0;
            from_decode <= 1'b0;
            wait_cnt    <= CNT_LOAD;
        end else begin
            state       <= next_state;
            from_decode <= (state == S_DECODE);
            if ((state == S_FETCH) && accept) ir <= instr;
            // A FETCH retry after a timeout gets a fresh wait window.
            if ((next_state != state) || timeout)
                wait_cnt <= CNT_LOAD;
            else if (waiting && !mem_ready && (wait_cnt != '0))
                wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: an instruction-level model expands each test
// instruction into per-cycle stimulus and expected outputs, checked every cycle.
module tb_cpu_ctrl_fsm;

    localparam int REG_N = 8;
    localparam int SEL_W = 3;
    localparam int MT    = 4;

    // strobe bit positions in {flag_en,alu_sel,addr_sel,mem_req,mem_we,pc_en,pc_sel,illegal,bus_err}
    localparam int FE = 8, AS = 7, AD = 6, RQ = 5, WE = 4, PE = 3, PS = 2, IL = 1, BE = 0;

    logic              clk = 1'b0;
    logic              reset;
    logic [15:0]       instr;
    logic              mem_ready;
    logic [4:0]        flags;
    logic [15:0]       ir;
    logic [7:0]        alu_op;
    logic [SEL_W-1:0]  ra_sel;
    logic [SEL_W-1:0]  rb_sel;
    logic [REG_N-1:0]  reg_en;
    logic              flag_en, alu_sel, addr_sel, mem_req, mem_we, pc_en, pc_sel, illegal, bus_err;

    cpu_ctrl_fsm #(.REG_N(REG_N), .SEL_W(SEL_W), .MEM_TIMEOUT(MT)) dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_ready(mem_ready), .flags(flags),
        .ir(ir), .alu_op(alu_op), .ra_sel(ra_sel), .rb_sel(rb_sel), .reg_en(reg_en),
        .flag_en(flag_en), .alu_sel(alu_sel), .addr_sel(addr_sel), .mem_req(mem_req),
        .mem_we(mem_we), .pc_en(pc_en), .pc_sel(pc_sel), .illegal(illegal), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] din;
        logic        rdy;
        logic [4:0]  fl;
        logic        chk_ir;
        logic [15:0] ir;
        logic [7:0]  reg_en;
        logic [8:0]  strb;
    } vec_t;

    vec_t        q[$];
    logic [7:0]  obs_reg_en[$];
    logic [8:0]  obs_strb[$];
    logic [15:0] m_ir;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic void check(input string nm, input int cyc, input logic [15:0] act,
                                  input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic rst, input logic [15:0] din, input logic rdy,
                                input logic [4:0] fl);
        vec_t v;
        v.rst = rst; v.din = din; v.rdy = rdy; v.fl = fl;
        v.chk_ir = 1'b1; v.ir = m_ir; v.reg_en = '0; v.strb = '0;
        return v;
    endfunction

    function automatic logic cond_taken(input logic [3:0] c, input logic [4:0] f);
        logic n, z, ff, l, cy;
        logic [15:0] t;
        n = f[4]; z = f[3]; ff = f[2]; l = f[1]; cy = f[0];
        t = {1'b0, 1'b1, n | z, !n & !z, l | z, !l & !z, !ff, ff,
             !n, n, !l, l, !cy, cy, !z, z};
        return t[c];
    endfunction

    function automatic logic [7:0] hot(input logic [3:0] r);
        logic [7:0] one8;
        one8 = 8'h01;
        return one8 << r;
    endfunction

    task automatic do_reset(input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v = mk(1'b1, 16'h0000, 1'b0, 5'b0);
            if (q.size() == 0) v.chk_ir = 1'b0;
            q.push_back(v);
            m_ir = '0;
        end
        q.push_back(mk(1'b0, 16'h0000, 1'b1, 5'b0));
    endtask

    task automatic fetch(input logic [15:0] ins, input int waits);
        vec_t v;
        int   miss;
        miss = 0;
        for (int i = 0; i < waits; i++) begin
            v = mk(1'b0, 16'hDEAD, 1'b0, 5'b0);
            miss++;
            if (miss == MT) begin
                v.strb[BE] = 1'b1;
                miss = 0;
            end else begin
                v.strb[RQ] = 1'b1;
            end
            q.push_back(v);
        end
        v = mk(1'b0, ins, 1'b1, 5'b0);
        v.strb[RQ] = 1'b1;
        q.push_back(v);
        m_ir = ins;
    endtask

    // fw / mw: mem_ready-low cycles in FETCH and in the LOAD/STORE data phase
    task automatic run(input logic [15:0] ins, input int fw, input int mw,
                       input logic [4:0] fl, output int last);
        logic [3:0] cls, rd, ex, rs;
        logic       st, bad;
        vec_t       v;
        cls = ins[15:12]; rd = ins[11:8]; ex = ins[7:4]; rs = ins[3:0];
        fetch(ins, fw);
        v = mk(1'b0, 16'hBEEF, 1'b1, fl);
        if (cls == 4'h4 && ex != 4'h0 && ex != 4'h4 && ex != 4'hC) begin
            v.strb[IL] = 1'b1;
            v.strb[PE] = 1'b1;
            q.push_back(v);
            last = q.size() - 1;
            return;
        end
        q.push_back(v);
        if (cls != 4'h4) begin
            v = mk(1'b0, 16'hBEEF, 1'b1, fl);
            v.strb[FE] = 1'b1; v.strb[AS] = 1'b1; v.strb[PE] = 1'b1;
            if (!(cls == 4'h0 && ex == 4'hB)) begin
                if (int'(rd) >= REG_N) v.strb[IL] = 1'b1;
                else                   v.reg_en = hot(rd);
            end
            q.push_back(v);
        end else if (ex == 4'hC) begin
            v = mk(1'b0, 16'hBEEF, 1'b1, fl);
            v.strb[PE] = 1'b1;
            if (int'(rs) >= REG_N) v.strb[IL] = 1'b1;
            else                   v.strb[PS] = cond_taken(rd, fl);
            q.push_back(v);
        end else begin
            st  = (ex == 4'h4);
            bad = (int'(rd) >= REG_N) || (int'(rs) >= REG_N);
            v = mk(1'b0, 16'hBEEF, 1'b0, fl);
            v.strb[RQ] = 1'b1; v.strb[AD] = 1'b1; v.strb[WE] = st && !bad;
            q.push_back(v);
            for (int k = 1; k <= mw; k++) begin
                v = mk(1'b0, 16'hBEEF, 1'b0, fl);
                v.strb[AD] = 1'b1;
                if (k == MT) begin
                    v.strb[BE] = 1'b1;
                    v.strb[PE] = 1'b1;
                    q.push_back(v);
                    last = q.size() - 1;
                    return;
                end
                v.strb[RQ] = 1'b1;
                v.strb[WE] = st && !bad;
                q.push_back(v);
            end
            v = mk(1'b0, 16'h5A5A, 1'b1, fl);
            v.strb[RQ] = 1'b1; v.strb[AD] = 1'b1; v.strb[PE] = 1'b1;
            v.strb[WE] = st && !bad;
            if (bad)     v.strb[IL] = 1'b1;
            else if (!st) v.reg_en = hot(rd);
            q.push_back(v);
        end
        last = q.size() - 1;
    endtask

    initial begin
        int   s, t;
        int   i_add, n_add, i_a2, i_ld, n_ld, i_jt, i_jn, i_st, n_st, i_bad, i_dec, i_rst;
        vec_t v;

        m_ir = '0;
        reset = 1'b1; instr = '0; mem_ready = 1'b0; flags = '0;

        do_reset(3);
        s = q.size(); run(16'h0152, 0, 0, 5'b0, i_add); n_add = i_add - s + 1;
        run(16'h0512, 0, 0, 5'b0, i_a2);
        run(16'h01B2, 0, 0, 5'b0, t);
        s = q.size(); run(16'h4303, 0, 2, 5'b0, i_ld); n_ld = i_ld - s + 1;
        run(16'h40C5, 0, 0, 5'b01000, i_jt);
        run(16'h40C5, 0, 0, 5'b00000, i_jn);
        s = q.size(); run(16'h4245, 0, 10, 5'b0, i_st); n_st = i_st - s + 1;
        run(16'h4245, 1, 1, 5'b0, t);
        run(16'h0A12, 0, 0, 5'b0, i_bad);
        run(16'h4170, 0, 0, 5'b0, i_dec);
        run(16'h0623, 5, 0, 5'b0, t);
        run(16'h4309, 0, 1, 5'b0, t);
        run(16'h4903, 0, 0, 5'b0, t);
        run(16'h4A45, 0, 0, 5'b0, t);
        run(16'h4EC9, 0, 0, 5'b11111, t);
        run(16'h0BB2, 0, 0, 5'b0, t);
        run(16'h4204, 0, 3, 5'b0, t);
        run(16'h4347, 0, 3, 5'b0, t);
        for (int c = 0; c < 16; c++) begin
            run({4'h4, 4'(c), 4'hC, 4'h3}, 0, 0, 5'b10110, t);
            run({4'h4, 4'(c), 4'hC, 4'h3}, 0, 0, 5'b01001, t);
        end
        // reset lands in the second cycle of a LOAD data wait
        fetch(16'h4303, 0);
        q.push_back(mk(1'b0, 16'hBEEF, 1'b1, 5'b0));
        v = mk(1'b0, 16'hBEEF, 1'b0, 5'b0); v.strb[RQ] = 1'b1; v.strb[AD] = 1'b1; q.push_back(v);
        q.push_back(v);
        i_rst = q.size();
        do_reset(1);
        run(16'h0152, 0, 0, 5'b0, t);

        for (int i = 0; i < q.size(); i++) begin
            v = q[i];
            reset = v.rst; instr = v.din; mem_ready = v.rdy; flags = v.fl;
            #1;
            if (v.chk_ir) begin
                check("ir", i, ir, v.ir);
                check("alu_op", i, 16'(alu_op), 16'({v.ir[15:12], v.ir[7:4]}));
                check("ra_sel", i, 16'(ra_sel), 16'(v.ir[10:8]));
                check("rb_sel", i, 16'(rb_sel), 16'(v.ir[2:0]));
            end
            check("reg_en", i, 16'(reg_en), 16'(v.reg_en));
            check("strobes", i,
                  16'({flag_en, alu_sel, addr_sel, mem_req, mem_we, pc_en, pc_sel, illegal, bus_err}),
                  16'(v.strb));
            obs_reg_en.push_back(reg_en);
            obs_strb.push_back({flag_en, alu_sel, addr_sel, mem_req, mem_we, pc_en, pc_sel, illegal, bus_err});
            @(negedge clk);
        end

        check("pin_add_cycles", i_add, 16'(n_add), 16'd3);
        check("pin_add_reg_en", i_add, 16'(obs_reg_en[i_add]), 16'h0002);
        check("pin_add_strb", i_add, 16'(obs_strb[i_add]), 16'h0188);
        check("pin_add0512_reg_en", i_a2, 16'(obs_reg_en[i_a2]), 16'h0020);
        check("pin_ld_cycles", i_ld, 16'(n_ld), 16'd6);
        check("pin_ld_reg_en", i_ld, 16'(obs_reg_en[i_ld]), 16'h0008);
        check("pin_ld_strb", i_ld, 16'(obs_strb[i_ld]), 16'h0068);
        check("pin_ld_wait_reg_en", i_ld - 1, 16'(obs_reg_en[i_ld - 1]), 16'h0000);
        check("pin_jeq_taken", i_jt, 16'(obs_strb[i_jt]), 16'h000C);
        check("pin_jeq_not_taken", i_jn, 16'(obs_strb[i_jn]), 16'h0008);
        check("pin_st_timeout_cycles", i_st, 16'(n_st), 16'd7);
        check("pin_st_timeout_strb", i_st, 16'(obs_strb[i_st]), 16'h0049);
        check("pin_bad_rdest_strb", i_bad, 16'(obs_strb[i_bad]), 16'h018A);
        check("pin_bad_rdest_reg_en", i_bad, 16'(obs_reg_en[i_bad]), 16'h0000);
        check("pin_bad_ext_strb", i_dec, 16'(obs_strb[i_dec]), 16'h000A);
        check("pin_reset_strb", i_rst, 16'(obs_strb[i_rst]), 16'h0000);
        check("pin_reset_reg_en", i_rst, 16'(obs_reg_en[i_rst]), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
